arm_prog_loader: RTL and testbench
==================================

# arm_prog_loader

Hardware program loader and run supervisor for the ARM core. It accepts a program as a valid/ready word stream and writes it into the unified memory's data port at consecutive word addresses, holding the core in reset throughout. It then releases the core, counts execution cycles until `halted`, and aborts on a configurable watchdog timeout. It sits between the memory write port, the core's reset input and a host/stimulus source, and replaces file-driven preloading with a synthesizable, restartable sequence.

## Interface
- `DATA_W`, 32, word width of stream and memory data
- `ADDR_W`, 32, memory byte-address width
- `BASE_ADDR`, 0, byte address of first program word
- `MAX_WORDS`, 1024, program capacity in words (≥1)
- `TIMEOUT`, 65535, run-cycle watchdog limit; 0 disables the watchdog
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle request to begin a load
- `ld_valid`  in  1  stream word valid
- `ld_data`  in  DATA_W  stream word
- `ld_last`  in  1  marks final program word
- `ld_ready`  out  1  loader accepts stream word
- `mem_addr`  out  ADDR_W  memory write byte address
- `mem_data_in`  out  DATA_W  memory write data
- `mem_write_en`  out  1  memory write strobe
- `core_rst`  out  1  active-high reset to the core
- `halted`  in  1  core halt indication
- `done`  out  1  program halted normally
- `timed_out`  out  1  watchdog expired
- `overflow`  out  1  stream exceeded MAX_WORDS
- `word_count`  out  $clog2(MAX_WORDS+1)  words written this load
- `cycle_count`  out  32  cycles core ran with core_rst low

## Operation
- States: IDLE, LOAD, RUN, DONE, ERROR.
- Reset values: state IDLE, `core_rst`=1, `mem_write_en`=0, `mem_addr`=BASE_ADDR, `mem_data_in`=0, `ld_ready`=0, `done`/`timed_out`/`overflow`=0, both counts 0.
- IDLE: `start` → LOAD; clear counts and flags.
- LOAD: `ld_ready`=1 (combinational from state). Handshake = `ld_valid & ld_ready`.
  - Handshake with `word_count` < MAX_WORDS: register `mem_addr`=BASE_ADDR+4·`word_count` (mod 2^ADDR_W), `mem_data_in`=`ld_data`, `mem_write_en`=1 for exactly one cycle; `word_count`+1. If `ld_last`, go to RUN.
  - Handshake with `word_count`==MAX_WORDS: no write, `overflow`=1, go to ERROR.
  - No handshake: `mem_write_en`=0; `mem_addr`/`mem_data_in` hold.
- RUN: `core_rst`=0; `cycle_count`+1 per cycle (saturates at 2^32−1). `halted`=1 → DONE. TIMEOUT≠0 and `cycle_count`==TIMEOUT−1 with `halted`=0 → ERROR, `timed_out`=1.
- DONE: `done`=1, `core_rst`=1. ERROR: `core_rst`=1, flag held.
- DONE/ERROR + `start` → LOAD (clear counts, flags). `start` ignored in LOAD and RUN.
- `halted` ignored outside RUN.

## Timing
- Handshake at edge E: write strobe visible E→E+1; memory captures at E+1.
- `ld_last` handshake at E: state RUN from E; `core_rst` is registered and falls at E+1, so the core first leaves reset after the last write commits. Back-to-back words sustain one word per cycle.
- `cycle_count` counts cycles with `core_rst`=0. `halted` sampled at edge H → `done`=1 and `core_rst`=1 at H.
- Watchdog: with `core_rst` low from edge R, ERROR is entered at edge R+TIMEOUT unless `halted` was sampled earlier; `halted` and expiry on the same edge → DONE (halt wins).
- `start` in IDLE at edge S → `ld_ready`=1 after S.
- `rst_n` low at any time: all outputs to reset values immediately (asynchronous); partially written memory is undefined; `core_rst` stays high until the next full load.

## Test plan
- Normal load: start, stream 0xE3A00001, 0xE3A01002, 0xEF000000 (last) back-to-back, BASE_ADDR=0 → writes at 0x0/0x4/0x8 on consecutive cycles, `word_count`=3, `core_rst` falls 1 cycle after last write; `halted` after 10 cycles → `done`=1, `cycle_count`=10.
- Backpressure/gaps: `ld_valid` toggled 1,0,0,1 with BASE_ADDR=0x100 → exactly 2 one-cycle strobes, addresses 0x100, 0x104, no writes in gap cycles.
- Overflow: MAX_WORDS=4, stream 5 words without `ld_last` → 4 writes, 5th not written, `overflow`=1, ERROR, `core_rst` stays 1.
- Watchdog: TIMEOUT=16, `halted` never asserts → `timed_out`=1 at cycle 16 of run, `core_rst` reasserted; repeat with `halted` at cycle 16 → `done`=1, `timed_out`=0.
- Reset mid-load: `rst_n` low after 2 of 3 words → all outputs at reset values asynchronously, `word_count`=0; fresh start reloads from BASE_ADDR.
- Restart: after DONE, pulse `start`, load 1 word → flags and counts cleared, write at BASE_ADDR; `start` pulses during LOAD/RUN have no effect.

Source files
------------

// File: rtl/arm_prog_loader_if.sv
// Program stream and memory write port of the ARM program loader.
// The master modport is the loader's view; the slave modport is the host and memory side.
interface arm_prog_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_write_en;

  modport master (
    input  ld_valid, ld_data, ld_last,
    output ld_ready, mem_addr, mem_data_in, mem_write_en
  );

  modport slave (
    output ld_valid, ld_data, ld_last,
    input  ld_ready, mem_addr, mem_data_in, mem_write_en
  );
endinterface

// File: rtl/arm_prog_loader.sv
// Streams a program into the unified memory while holding the ARM core in reset,
// then releases the core and supervises it until halt or watchdog expiry.
module arm_prog_loader #(
  parameter int               DATA_W    = 32,
  parameter int               ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int               MAX_WORDS = 1024,
  parameter int               TIMEOUT   = 65535,
  localparam int              WC_W      = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halted,
  arm_prog_loader_if.master bus,
  output logic             core_rst,
  output logic             done,
  output logic             timed_out,
  output logic             overflow,
  output logic [WC_W-1:0]  word_count,
  output logic [31:0]      cycle_count
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ERROR} state_t;

  localparam logic [WC_W-1:0] WC_MAX  = WC_W'(MAX_WORDS);
  localparam logic [31:0]     TO_LAST = 32'(TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic [WC_W-1:0]   word_count_reg, word_count_next;
  logic [31:0]       cycle_count_reg, cycle_count_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_data_reg, mem_data_next;
  logic              mem_we_reg, mem_we_next;
  logic              core_rst_reg, core_rst_next;
  logic              timed_out_reg, timed_out_next;
  logic              overflow_reg, overflow_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      word_count_reg  <= '0;
      cycle_count_reg <= '0;
      mem_addr_reg    <= BASE_ADDR;
      mem_data_reg    <= '0;
      mem_we_reg      <= 1'b0;
      core_rst_reg    <= 1'b1;
      timed_out_reg   <= 1'b0;
      overflow_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      word_count_reg  <= word_count_next;
      cycle_count_reg <= cycle_count_next;
      mem_addr_reg    <= mem_addr_next;
      mem_data_reg    <= mem_data_next;
      mem_we_reg      <= mem_we_next;
      core_rst_reg    <= core_rst_next;
      timed_out_reg   <= timed_out_next;
      overflow_reg    <= overflow_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    word_count_next  = word_count_reg;
    cycle_count_next = cycle_count_reg;
    mem_addr_next    = mem_addr_reg;
    mem_data_next    = mem_data_reg;
    mem_we_next      = 1'b0;
    core_rst_next    = 1'b1;
    timed_out_next   = timed_out_reg;
    overflow_next    = overflow_reg;

    // Count every cycle the core actually ran, including the one that ends in halt or expiry.
    if (!core_rst_reg && (cycle_count_reg != '1))
      cycle_count_next = cycle_count_reg + 32'd1;

    case (state_reg)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_next       = LOAD;
          word_count_next  = '0;
          cycle_count_next = '0;
          timed_out_next   = 1'b0;
          overflow_next    = 1'b0;
        end
      end
      LOAD: begin
        if (bus.ld_valid) begin
          if (word_count_reg == WC_MAX) begin
            overflow_next = 1'b1;
            state_next    = ERROR;
          end else begin
            mem_addr_next   = BASE_ADDR + ADDR_W'({word_count_reg, 2'b00});
            mem_data_next   = bus.ld_data;
            mem_we_next     = 1'b1;
            word_count_next = word_count_reg + WC_W'(1);
            if (bus.ld_last)
              state_next = RUN;
          end
        end
      end
      RUN: begin
        // The first RUN cycle still has the core in reset, so halt and expiry wait for it to leave.
        if (!core_rst_reg && halted) begin
          state_next = DONE;
        end else if ((TIMEOUT != 0) && !core_rst_reg && (cycle_count_reg == TO_LAST)) begin
          state_next     = ERROR;
          timed_out_next = 1'b1;
        end else begin
          core_rst_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.ld_ready     = (state_reg == LOAD);
  assign bus.mem_addr     = mem_addr_reg;
  assign bus.mem_data_in  = mem_data_reg;
  assign bus.mem_write_en = mem_we_reg;
  assign core_rst         = core_rst_reg;
  assign done             = (state_reg == DONE);
  assign timed_out        = timed_out_reg;
  assign overflow         = overflow_reg;
  assign word_count       = word_count_reg;
  assign cycle_count      = cycle_count_reg;

endmodule

// File: tb/tb_arm_prog_loader.sv
// Directed bench for arm_prog_loader: load, backpressure, overflow, watchdog, reset and restart.
module tb_arm_prog_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // dut_a: BASE 0, capacity 4 words, watchdog 16 cycles
  logic        start_a = 1'b0, halted_a = 1'b0;
  logic        core_rst_a, done_a, to_a, ov_a;
  logic [2:0]  wc_a;
  logic [31:0] cc_a;
  arm_prog_loader_if #(.DATA_W(32), .ADDR_W(32)) bus_a ();

  arm_prog_loader #(.DATA_W(32), .ADDR_W(32), .BASE_ADDR(32'h0), .MAX_WORDS(4), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .halted(halted_a), .bus(bus_a.master),
    .core_rst(core_rst_a), .done(done_a), .timed_out(to_a), .overflow(ov_a),
    .word_count(wc_a), .cycle_count(cc_a)
  );

  // dut_b: BASE 0x100, default capacity, watchdog disabled
  logic        start_b = 1'b0, halted_b = 1'b0;
  logic        core_rst_b, done_b, to_b, ov_b;
  logic [10:0] wc_b;
  logic [31:0] cc_b;
  arm_prog_loader_if #(.DATA_W(32), .ADDR_W(32)) bus_b ();

  arm_prog_loader #(.DATA_W(32), .ADDR_W(32), .BASE_ADDR(32'h100), .MAX_WORDS(1024), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .halted(halted_b), .bus(bus_b.master),
    .core_rst(core_rst_b), .done(done_b), .timed_out(to_b), .overflow(ov_b),
    .word_count(wc_b), .cycle_count(cc_b)
  );

  int strobes_a = 0, strobes_b = 0;
  always @(negedge clk) begin
    if (bus_a.mem_write_en === 1'b1) strobes_a <= strobes_a + 1;
    if (bus_b.mem_write_en === 1'b1) strobes_b <= strobes_b + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s 0x%08h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_a(input logic v, input logic [31:0] d, input logic l);
    bus_a.ld_valid = v;
    bus_a.ld_data  = d;
    bus_a.ld_last  = l;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] d, input logic l);
    bus_b.ld_valid = v;
    bus_b.ld_data  = d;
    bus_b.ld_last  = l;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int s0;
    drive_a(1'b0, 32'h0, 1'b0);
    drive_b(1'b0, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    tick(2);

    // reset values
    check_eq("rst_core_rst", core_rst_a, 1);
    check_eq("rst_we", bus_a.mem_write_en, 0);
    check_eq("rst_addr", bus_a.mem_addr, 32'h0);
    check_eq("rst_data", bus_a.mem_data_in, 0);
    check_eq("rst_ready", bus_a.ld_ready, 0);
    check_eq("rst_flags", {done_a, to_a, ov_a}, 0);
    check_eq("rst_wc", wc_a, 0);
    check_eq("rst_cc", cc_a, 0);
    check_eq("rst_addr_b", bus_b.mem_addr, 32'h100);
    rst_n = 1'b1;
    tick(1);

    // normal load of three words, then halt after 10 run cycles
    start_a = 1'b1; tick(1); start_a = 1'b0;
    check_eq("t1_ready", bus_a.ld_ready, 1);
    s0 = strobes_a;
    drive_a(1'b1, 32'hE3A00001, 1'b0); tick(1);
    check_eq("t1_w0_we", bus_a.mem_write_en, 1);
    check_eq("t1_w0_addr", bus_a.mem_addr, 32'h0);
    check_eq("t1_w0_data", bus_a.mem_data_in, 32'hE3A00001);
    check_eq("t1_w0_wc", wc_a, 1);
    drive_a(1'b1, 32'hE3A01002, 1'b0); tick(1);
    check_eq("t1_w1_addr", bus_a.mem_addr, 32'h4);
    check_eq("t1_w1_data", bus_a.mem_data_in, 32'hE3A01002);
    drive_a(1'b1, 32'hEF000000, 1'b1); tick(1);
    check_eq("t1_w2_addr", bus_a.mem_addr, 32'h8);
    check_eq("t1_w2_data", bus_a.mem_data_in, 32'hEF000000);
    check_eq("t1_w2_wc", wc_a, 3);
    check_eq("t1_w2_core_rst", core_rst_a, 1);
    drive_a(1'b0, 32'h0, 1'b0); tick(1);
    check_eq("t1_run_we", bus_a.mem_write_en, 0);
    check_eq("t1_run_core_rst", core_rst_a, 0);
    check_eq("t1_run_cc0", cc_a, 0);
    check_eq("t1_strobes", strobes_a - s0, 3);
    tick(9);
    check_eq("t1_cc9", cc_a, 9);
    halted_a = 1'b1; tick(1); halted_a = 1'b0;
    check_eq("t1_done", done_a, 1);
    check_eq("t1_done_core_rst", core_rst_a, 1);
    check_eq("t1_cc10", cc_a, 10);
    tick(1);
    check_eq("t1_cc_hold", cc_a, 10);

    // overflow with capacity 4; a start pulse mid-load must be ignored
    start_a = 1'b1; tick(1); start_a = 1'b0;
    check_eq("t2_cleared", {done_a, wc_a, cc_a[7:0]}, 0);
    s0 = strobes_a;
    for (int k = 0; k < 4; k++) begin
      drive_a(1'b1, 32'h1000 + k, 1'b0);
      start_a = (k == 2);
      tick(1);
      start_a = 1'b0;
      check_eq($sformatf("t2_w%0d_addr", k), bus_a.mem_addr, 32'(4 * k));
      check_eq($sformatf("t2_w%0d_wc", k), wc_a, k + 1);
    end
    drive_a(1'b1, 32'h1004, 1'b0); tick(1);
    drive_a(1'b0, 32'h0, 1'b0);
    check_eq("t2_ov_we", bus_a.mem_write_en, 0);
    check_eq("t2_ov_flag", ov_a, 1);
    check_eq("t2_ov_wc", wc_a, 4);
    check_eq("t2_ov_ready", bus_a.ld_ready, 0);
    check_eq("t2_ov_addr_hold", bus_a.mem_addr, 32'hC);
    tick(3);
    check_eq("t2_ov_core_rst", core_rst_a, 1);
    check_eq("t2_ov_held", ov_a, 1);
    check_eq("t2_strobes", strobes_a - s0, 4);

    // watchdog expiry at run cycle 16
    start_a = 1'b1; tick(1); start_a = 1'b0;
    check_eq("t3_ov_clear", ov_a, 0);
    drive_a(1'b1, 32'hEAFFFFFE, 1'b1); tick(1);
    drive_a(1'b0, 32'h0, 1'b0);
    check_eq("t3_w_addr", bus_a.mem_addr, 32'h0);
    tick(1);
    check_eq("t3_core_rst0", core_rst_a, 0);
    tick(15);
    check_eq("t3_cc15", cc_a, 15);
    check_eq("t3_to_early", to_a, 0);
    tick(1);
    check_eq("t3_to", to_a, 1);
    check_eq("t3_core_rst1", core_rst_a, 1);
    check_eq("t3_cc16", cc_a, 16);
    check_eq("t3_not_done", done_a, 0);
    tick(2);
    check_eq("t3_to_held", to_a, 1);

    // halt on the expiry edge wins; start pulse during RUN ignored
    start_a = 1'b1; tick(1); start_a = 1'b0;
    check_eq("t4_to_clear", to_a, 0);
    drive_a(1'b1, 32'hE1A00000, 1'b1); tick(1);
    drive_a(1'b0, 32'h0, 1'b0);
    tick(1);
    check_eq("t4_core_rst0", core_rst_a, 0);
    tick(5);
    start_a = 1'b1; tick(1); start_a = 1'b0;
    check_eq("t4_run_start_cc", cc_a, 6);
    check_eq("t4_run_start_ready", bus_a.ld_ready, 0);
    tick(9);
    halted_a = 1'b1; tick(1); halted_a = 1'b0;
    check_eq("t4_done", done_a, 1);
    check_eq("t4_to", to_a, 0);
    check_eq("t4_cc16", cc_a, 16);

    // asynchronous reset after two of three words, then reload
    start_a = 1'b1; tick(1); start_a = 1'b0;
    drive_a(1'b1, 32'h11111111, 1'b0); tick(1);
    drive_a(1'b1, 32'h22222222, 1'b0); tick(1);
    check_eq("t5_pre_wc", wc_a, 2);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t5_we", bus_a.mem_write_en, 0);
    check_eq("t5_wc", wc_a, 0);
    check_eq("t5_addr", bus_a.mem_addr, 32'h0);
    check_eq("t5_data", bus_a.mem_data_in, 0);
    check_eq("t5_ready", bus_a.ld_ready, 0);
    check_eq("t5_core_rst", core_rst_a, 1);
    drive_a(1'b0, 32'h0, 1'b0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    start_a = 1'b1; tick(1); start_a = 1'b0;
    check_eq("t5_reload_ready", bus_a.ld_ready, 1);
    drive_a(1'b1, 32'h33333333, 1'b1); tick(1);
    drive_a(1'b0, 32'h0, 1'b0);
    check_eq("t5_reload_addr", bus_a.mem_addr, 32'h0);
    check_eq("t5_reload_data", bus_a.mem_data_in, 32'h33333333);
    check_eq("t5_reload_wc", wc_a, 1);
    tick(1);
    check_eq("t5_reload_core_rst", core_rst_a, 0);

    // backpressure with gaps at BASE 0x100
    start_b = 1'b1; tick(1); start_b = 1'b0;
    s0 = strobes_b;
    drive_b(1'b1, 32'hA0, 1'b0); tick(1);
    check_eq("t6_w0_we", bus_b.mem_write_en, 1);
    check_eq("t6_w0_addr", bus_b.mem_addr, 32'h100);
    drive_b(1'b0, 32'hDEAD, 1'b0); tick(1);
    check_eq("t6_gap0_we", bus_b.mem_write_en, 0);
    check_eq("t6_gap0_addr", bus_b.mem_addr, 32'h100);
    tick(1);
    check_eq("t6_gap1_we", bus_b.mem_write_en, 0);
    drive_b(1'b1, 32'hA1, 1'b1); tick(1);
    check_eq("t6_w1_we", bus_b.mem_write_en, 1);
    check_eq("t6_w1_addr", bus_b.mem_addr, 32'h104);
    check_eq("t6_w1_data", bus_b.mem_data_in, 32'hA1);
    check_eq("t6_w1_wc", wc_b, 2);
    drive_b(1'b0, 32'h0, 1'b0); tick(1);
    check_eq("t6_strobes", strobes_b - s0, 2);
    check_eq("t6_core_rst0", core_rst_b, 0);

    // watchdog disabled: run well past 16 cycles, then halt
    tick(40);
    check_eq("t7_cc40", cc_b, 40);
    check_eq("t7_no_to", to_b, 0);
    check_eq("t7_still_run", core_rst_b, 0);
    halted_b = 1'b1; tick(1); halted_b = 1'b0;
    check_eq("t7_done", done_b, 1);
    check_eq("t7_cc41", cc_b, 41);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
